// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-lane RAM.
package ram_pkg;

    typedef enum logic {CLEAR, READY} ram_state_t;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned nb_lanes(input int unsigned data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte lane: DEPTH x 8 array, one write port, two registered read ports with write bypass.
module ram_lane
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [BYTE_W-1:0]     i_wdata,
    input  logic                  i_rd_load,
    input  logic                  i_rd_zero,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_fe_load,
    input  logic                  i_fe_zero,
    input  logic [ADDR_WIDTH-1:0] i_fe_addr,
    output logic [BYTE_W-1:0]     o_rd_data,
    output logic [BYTE_W-1:0]     o_fe_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rd_data_d, rd_data_q;
    logic [BYTE_W-1:0] fe_data_d, fe_data_q;

    // Load/zero strobes are only raised for accepted requests, so addresses here are in range.
    always_comb begin
        rd_data_d = rd_data_q;
        fe_data_d = fe_data_q;
        if (i_rd_zero) begin
            rd_data_d = '0;
        end else if (i_rd_load) begin
            rd_data_d = (i_we && (i_waddr == i_rd_addr)) ? i_wdata : mem[IDX_W'(i_rd_addr)];
        end
        if (i_fe_zero) begin
            fe_data_d = '0;
        end else if (i_fe_load) begin
            fe_data_d = (i_we && (i_waddr == i_fe_addr)) ? i_wdata : mem[IDX_W'(i_fe_addr)];
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[IDX_W'(i_waddr)] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            fe_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            fe_data_q <= fe_data_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_fe_data = fe_data_q;

endmodule

// File: rtl/byte_ram_sync.sv
// Byte-enabled RAM with data and fetch read ports, range checking and post-reset clear.
module byte_ram_sync
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_en,
    output logic                             o_busy,
    input  logic                             i_read_req,
    input  logic [ADDR_WIDTH-1:0]            i_read_addr,
    output logic [DATA_WIDTH-1:0]            o_read_data,
    output logic                             o_read_valid,
    input  logic                             i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]            i_fetch_addr,
    output logic [DATA_WIDTH-1:0]            o_fetch_data,
    output logic                             o_fetch_valid,
    input  logic                             i_write_enable,
    input  logic [nb_lanes(DATA_WIDTH)-1:0]  i_byte_enable,
    input  logic [ADDR_WIDTH-1:0]            i_write_addr,
    input  logic [DATA_WIDTH-1:0]            i_write_data,
    output logic                             o_addr_err
);

    localparam int unsigned         NB_LANES  = nb_lanes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam ram_state_t          RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    ram_state_t state_d, state_q;
    logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;
    logic busy_d, busy_q;
    logic read_valid_d, read_valid_q;
    logic fetch_valid_d, fetch_valid_q;
    logic addr_err_d, addr_err_q;

    logic clear_we, ready, rd_acc, fe_acc, wr_acc, rd_inr, fe_inr, wr_inr;
    logic [ADDR_WIDTH-1:0] lane_waddr;
    logic [NB_LANES-1:0]   lane_we;

    // Clear sequencer and acceptance/range decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        if (clk_en) begin
            case (state_q)
                CLEAR: begin
                    clear_we = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: ;
            endcase
        end
        busy_d = (state_d == CLEAR);

        ready  = (state_q == READY) && clk_en;
        rd_acc = ready && i_read_req;
        fe_acc = ready && i_fetch_req;
        wr_acc = ready && i_write_enable && (|i_byte_enable);
        rd_inr = {1'b0, i_read_addr}  < DEPTH_X;
        fe_inr = {1'b0, i_fetch_addr} < DEPTH_X;
        wr_inr = {1'b0, i_write_addr} < DEPTH_X;

        read_valid_d  = clk_en ? rd_acc : read_valid_q;
        fetch_valid_d = clk_en ? fe_acc : fetch_valid_q;
        addr_err_d    = clk_en ? ((rd_acc && !rd_inr) || (fe_acc && !fe_inr) || (wr_acc && !wr_inr))
                               : addr_err_q;

        lane_waddr = (state_q == CLEAR) ? cnt_q : i_write_addr;
        for (int k = 0; k < NB_LANES; k++) begin
            lane_we[k] = clear_we || (wr_acc && wr_inr && i_byte_enable[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RST_STATE;
            cnt_q         <= '0;
            busy_q        <= CLEAR_ON_RESET;
            read_valid_q  <= 1'b0;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            read_valid_q  <= read_valid_d;
            fetch_valid_q <= fetch_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    for (genvar g = 0; g < NB_LANES; g++) begin : g_lane
        ram_lane #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_we      (lane_we[g]),
            .i_waddr   (lane_waddr),
            .i_wdata   ((state_q == CLEAR) ? BYTE_W'(0) : i_write_data[g*BYTE_W +: BYTE_W]),
            .i_rd_load (rd_acc && rd_inr),
            .i_rd_zero (rd_acc && !rd_inr),
            .i_rd_addr (i_read_addr),
            .i_fe_load (fe_acc && fe_inr),
            .i_fe_zero (fe_acc && !fe_inr),
            .i_fe_addr (i_fetch_addr),
            .o_rd_data (o_read_data[g*BYTE_W +: BYTE_W]),
            .o_fe_data (o_fetch_data[g*BYTE_W +: BYTE_W])
        );
    end

    assign o_busy        = busy_q;
    assign o_read_valid  = read_valid_q;
    assign o_fetch_valid = fetch_valid_q;
    assign o_addr_err    = addr_err_q;

endmodule

// File: doc/byte_ram_sync.md
# byte_ram_sync

Parametrised byte-lane RAM with two registered read ports (data, fetch) and one byte-enabled write port, used as the unified instruction/data memory of the core. Both read ports have one-cycle latency and a valid flag. Write-to-read bypass runs per byte lane. Out-of-range accesses are detected and flagged. An optional post-reset clear sequencer zeroes the array before the block accepts traffic.

## Interface
- `ADDR_WIDTH`, default 10: word-address width.
- `DEPTH`, default 1024: number of words; must satisfy `DEPTH <= 2**ADDR_WIDTH`.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8. `NB_LANES = DATA_WIDTH/8`.
- `CLEAR_ON_RESET`, default 1: 1 = zero the array after reset; 0 = array contents are undefined after reset.
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `clk_en` in 1: global enable. When it is 0, every register and memory holds its value.
- `o_busy` out 1: the clear sequence is in progress.
- `i_read_req` in 1: data read request.
- `i_read_addr` in ADDR_WIDTH: data read word address.
- `o_read_data` out DATA_WIDTH: data read result.
- `o_read_valid` out 1: `o_read_data` is valid.
- `i_fetch_req` in 1: fetch read request.
- `i_fetch_addr` in ADDR_WIDTH: fetch word address.
- `o_fetch_data` out DATA_WIDTH: fetch result.
- `o_fetch_valid` out 1: `o_fetch_data` is valid.
- `i_write_enable` in 1: write request.
- `i_byte_enable` in NB_LANES: per-lane write mask; bit k selects bits [8k+7:8k].
- `i_write_addr` in ADDR_WIDTH: write word address.
- `i_write_data` in DATA_WIDTH: write data.
- `o_addr_err` out 1: one-cycle flag; an accepted access was out of range.

## Operation
- States: `CLEAR` and `READY`.
  - Reset enters `CLEAR` if `CLEAR_ON_RESET=1`, otherwise `READY`.
  - In `CLEAR`, a counter runs from 0 to DEPTH-1. Each `clk_en` cycle writes 0 to all lanes at the counter address.
  - When the counter reaches DEPTH-1 with `clk_en` high, the state moves to `READY` and the counter returns to 0.
- In `CLEAR`, all requests are ignored: no writes, valids 0, `o_addr_err` 0.
- An access is accepted when the state is `READY`, `clk_en=1` and its request is high.
- Accepted read, in range (`addr < DEPTH`): the word is registered to `*_data` and `*_valid` is set at the next edge.
- Accepted read, out of range: data is 0, valid is 1, `o_addr_err` is 1.
- Accepted write, in range: lanes with their enable bit set are updated.
- Accepted write, out of range: the write is dropped and `o_addr_err` is 1. A write with `i_byte_enable=0` is a no-op and is never an error.
- `o_addr_err` is the OR of the error conditions from all three ports in the same cycle.
- Bypass: if a read and a write are accepted on the same edge to the same in-range address, the read returns the new byte for each enabled lane and the old byte for each other lane. This applies to the data and fetch ports independently.
- Both reads may target the same address in the same cycle; each returns the identical word.
- If `clk_en=1` and a port has no accepted request, its valid clears to 0 and its data register holds.

## Timing
- Reset values:
  - `o_read_data` and `o_fetch_data` = 0.
  - `o_read_valid`, `o_fetch_valid` and `o_addr_err` = 0.
  - `o_busy` = `CLEAR_ON_RESET`.
  - Clear counter = 0.
- Read latency is one cycle: a request sampled at edge N gives valid data after edge N. There is no backpressure, and one request per port is accepted every cycle.
- Write data is visible to a read sampled one edge later, and through bypass on the same edge.
- Clear takes exactly DEPTH `clk_en`-high cycles. `o_busy` falls at the edge that performs the last clear write. A request is accepted from the next edge onward.
- When `clk_en=0`, outputs including valids hold their values. A consumer must qualify valids with `clk_en`.
- Reset asserted in the middle of a clear returns to reset values and restarts the clear from address 0.

## Structure
- `ram_pkg` holds:
  - `typedef enum logic {CLEAR, READY} ram_state_t`
  - `localparam BYTE_W = 8`
  - the `NB_LANES` derivation function.
- Sub-module `ram_lane`: an 8-bit × DEPTH array with one write port and two synchronous read ports, each with its own bypass mux. It is instantiated NB_LANES times in a generate loop.
- The top level holds the FSM, the clear counter, range checks, the valid registers and the error OR.

## Test plan
- Clear (DEPTH=16): release `rst`; `o_busy` stays 1 for 16 cycles; then read addr 5 → `o_read_data=0x00000000`, `o_read_valid=1`.
- Byte enables: write 0xAABBCCDD to addr 3 with `be=4'b1111`, then 0x11223344 with `be=4'b0101` → read addr 3 returns 0xAA22CC44.
- Bypass: with addr 7 holding 0x12345678, write 0xFFFFFFFF with `be=4'b0011` while both ports read addr 7 on the same edge → both return 0x1234FFFF.
- Out of range (DEPTH=12, ADDR_WIDTH=4): write to addr 13 → `o_addr_err=1` for one cycle, memory unchanged; read addr 13 → data 0, valid 1, `o_addr_err=1`.
- `clk_en` gating: issue a read, then hold `clk_en=0` for 3 cycles → data and valid hold, and a write presented in those cycles is not performed.
- Reset mid-clear: assert `rst` during clear counter=6 → `o_busy` restarts, and the full clear takes 16 cycles after release.
